// File: rtl/rps_round_ctrl.sv
// rps_round_ctrl: one rock-paper-scissors round (countdown, gesture capture,
// LFSR opponent, result hold) plus saturating score keeping.
module rps_round_ctrl #(
   parameter int BEAT_CYCLES    = 1000,
   parameter int TIMEOUT_CYCLES = 4000,
   parameter int RESULT_CYCLES  = 2000,
   parameter int SCORE_W        = 4
) (
   input  logic               sck,
   input  logic               reset,
   input  logic               start,
   input  logic               done,
   input  logic [7:0]         SIG,
   output logic [2:0]         LED,
   output logic [2:0]         opp_led,
   output logic [1:0]         beat,
   output logic               busy,
   output logic               win,
   output logic               lose,
   output logic               tie,
   output logic [SCORE_W-1:0] p_score,
   output logic [SCORE_W-1:0] o_score
);
   localparam int MAX_BT = BEAT_CYCLES > TIMEOUT_CYCLES ? BEAT_CYCLES : TIMEOUT_CYCLES;
   localparam int MAX_C  = MAX_BT > RESULT_CYCLES ? MAX_BT : RESULT_CYCLES;
   localparam int CW     = $clog2(MAX_C);
   typedef enum logic [1:0] {IDLE, COUNT, WAIT, RESULT} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [7:0] lfsr;
   logic [2:0] gest, opp, led_n, opp_n;
   logic [1:0] beat_n;
   logic win_n, lose_n, tie_n, valid, beats_opp, sig_unused;
   logic [SCORE_W-1:0] p_n, o_n;
   assign gest = SIG[7:5];
   assign sig_unused = ^SIG[4:0];
   assign valid = done && (gest == 3'b100 || gest == 3'b010 || gest == 3'b001);
   assign opp = lfsr[1:0] == 2'd0 ? 3'b100 : lfsr[1:0] == 2'd1 ? 3'b010 : 3'b001;
   // A gesture beats whatever its one-hot code becomes when rotated left by one.
   assign beats_opp = {gest[1:0], gest[2]} == opp;
   always_comb begin
      state_n = state;
      cnt_n   = cnt + 1'b1;
      beat_n  = beat;
      led_n   = LED;
      opp_n   = opp_led;
      win_n   = win;
      lose_n  = lose;
      tie_n   = tie;
      p_n     = p_score;
      o_n     = o_score;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (start) begin
               state_n = COUNT;
               beat_n  = 2'd1;
            end
         end
         COUNT: if (cnt == CW'(BEAT_CYCLES - 1)) begin
            cnt_n   = '0;
            beat_n  = beat == 2'd3 ? 2'd0 : beat + 2'd1;
            state_n = beat == 2'd3 ? WAIT : COUNT;
         end
         WAIT: if (valid || cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state_n = RESULT;
            cnt_n   = '0;
            led_n   = valid ? gest : 3'b000;
            opp_n   = opp;
            tie_n   = valid && gest == opp;
            win_n   = valid && beats_opp;
            lose_n  = !(valid && (gest == opp || beats_opp));
         end
         RESULT: begin
            // Scores follow the registered outcome, applied once at the end of the first RESULT cycle.
            if (cnt == '0) begin
               p_n = win && p_score != '1 ? p_score + 1'b1 : p_score;
               o_n = lose && o_score != '1 ? o_score + 1'b1 : o_score;
            end
            if (cnt == CW'(RESULT_CYCLES - 1)) begin
               state_n = IDLE;
               cnt_n   = '0;
               led_n   = '0;
               opp_n   = '0;
               win_n   = 1'b0;
               lose_n  = 1'b0;
               tie_n   = 1'b0;
            end
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge sck or posedge reset)
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         lfsr    <= 8'h5A;
         beat    <= '0;
         busy    <= 1'b0;
         LED     <= '0;
         opp_led <= '0;
         win     <= 1'b0;
         lose    <= 1'b0;
         tie     <= 1'b0;
         p_score <= '0;
         o_score <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         lfsr    <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
         beat    <= beat_n;
         busy    <= state_n != IDLE;
         LED     <= led_n;
         opp_led <= opp_n;
         win     <= win_n;
         lose    <= lose_n;
         tie     <= tie_n;
         p_score <= p_n;
         o_score <= o_n;
      end
endmodule

// File: tb/tb_rps_round_ctrl.sv
// tb_rps_round_ctrl: directed rounds checked every cycle against a
// timeline model of the round, plus hand-computed literal checks.
module tb_rps_round_ctrl;
   localparam int B = 3, T = 30, R = 4, SW = 2;
   localparam int SMAX = (1 << SW) - 1;
   logic sck = 1'b0, reset = 1'b1, start = 1'b0, done = 1'b0;
   logic [7:0] SIG = 8'h00;
   logic [2:0] LED, opp_led;
   logic [1:0] beat;
   logic busy, win, lose, tie;
   logic [SW-1:0] p_score, o_score;
   logic [15:0] all_out;
   int checks = 0, failures = 0;
   typedef struct packed {
      int ph, k, r, p, o;
      logic [7:0] lf;
      logic [2:0] led, opp;
      logic w, l, t;
   } model_t;
   model_t m;
   rps_round_ctrl #(.BEAT_CYCLES(B), .TIMEOUT_CYCLES(T), .RESULT_CYCLES(R), .SCORE_W(SW)) dut (
      .sck(sck), .reset(reset), .start(start), .done(done), .SIG(SIG), .LED(LED), .opp_led(opp_led),
      .beat(beat), .busy(busy), .win(win), .lose(lose), .tie(tie), .p_score(p_score), .o_score(o_score));
   assign all_out = {LED, opp_led, beat, busy, win, lose, tie, p_score, o_score};
   always #5 sck = ~sck;
   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
      end
   endtask
   // ph: 0 idle, 1 countdown (k cycles since start), 2 waiting, 3 showing result (r cycles in).
   function automatic model_t step(input model_t c, input logic st, input logic dn, input logic [7:0] s);
      model_t n = c;
      int oi, d;
      logic ok;
      ok = dn && $countones(s[7:5]) == 1;
      if (c.ph == 0) begin
         if (st) begin
            n.ph = 1;
            n.k = 0;
         end
      end else if (c.ph == 1) begin
         n.k = c.k + 1;
         if (n.k == 3 * B) n.ph = 2;
      end else if (c.ph == 2) begin
         if (ok || c.k == 3 * B + T - 1) begin
            oi = c.lf[1:0] == 2'd3 ? 2 : int'(c.lf[1:0]);
            n.opp = 3'(3'b100 >> oi);
            n.ph = 3;
            n.r = 0;
            d = ok ? ((s[7] ? 0 : s[6] ? 1 : 2) - oi + 3) % 3 : 2;
            n.led = ok ? s[7:5] : 3'b000;
            n.t = d == 0;
            n.w = d == 1;
            n.l = d == 2;
         end else n.k = c.k + 1;
      end else begin
         if (c.r == 0) begin
            n.p = c.w && c.p < SMAX ? c.p + 1 : c.p;
            n.o = c.l && c.o < SMAX ? c.o + 1 : c.o;
         end
         if (c.r == R - 1) begin
            n.ph = 0;
            n.led = 0;
            n.opp = 0;
            n.w = 0;
            n.l = 0;
            n.t = 0;
         end else n.r = c.r + 1;
      end
      n.lf = {c.lf[6:0], c.lf[7] ^ c.lf[5] ^ c.lf[4] ^ c.lf[3]};
      return n;
   endfunction
   always @(posedge sck or posedge reset)
      if (reset) m <= '{ph: 0, k: 0, r: 0, p: 0, o: 0, lf: 8'h5A, led: 3'b0, opp: 3'b0, w: 1'b0, l: 1'b0, t: 1'b0};
      else m <= step(m, start, done, SIG);
   always @(negedge sck)
      if (!reset)
         check("outputs", int'(all_out), int'({m.led, m.opp, 2'(m.ph == 1 ? m.k / B + 1 : 0), m.ph != 0,
                                              m.w, m.l, m.t, SW'(m.p), SW'(m.o)}));
   task automatic wait_ph(input int p, input int lim);
      for (int n = 0; n < lim && m.ph != p; n++) @(negedge sck);
      check("phase_reached", m.ph, p);
   endtask
   task automatic start_round();
      @(negedge sck) start = 1'b1;
      @(negedge sck) start = 1'b0;
      wait_ph(2, 3 * B + 2);
   endtask
   task automatic send_when(input int need, input logic [7:0] s);
      for (int n = 0; n < T && !(m.ph == 2 && int'(m.lf[1:0]) >= need); n++) @(negedge sck);
      check("gesture_window", int'(m.ph == 2 && int'(m.lf[1:0]) >= need), 1);
      done = 1'b1;
      SIG = s;
      @(negedge sck) done = 1'b0;
      SIG = 8'h00;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required completion before 100000");
      $fatal(1);
   end
   initial begin
      int ob;
      repeat (3) @(negedge sck);
      check("reset_outputs", int'(all_out), 0);
      reset = 1'b0;
      @(negedge sck) start = 1'b1;
      @(negedge sck) start = 1'b0;
      check("lat_beat1", int'(beat), 1);
      check("lat_busy", int'(busy), 1);
      repeat (B) @(negedge sck);
      check("lat_beat2", int'(beat), 2);
      repeat (B) @(negedge sck);
      check("lat_beat3", int'(beat), 3);
      repeat (B) @(negedge sck);
      check("wait_beat0", int'({beat, busy}), 'b001);
      done = 1'b1;
      SIG = 8'hC0;
      @(negedge sck) done = 1'b0;
      SIG = 8'h00;
      check("multihot_ignored", int'({LED, win, lose, tie}), 0);
      send_when(3, 8'h80);
      check("win_led", int'(LED), 'b100);
      check("win_opp", int'(opp_led), 'b001);
      check("win_flags", int'({win, lose, tie}), 'b100);
      check("win_p_before", int'(p_score), 0);
      @(negedge sck);
      check("win_p_after", int'(p_score), 1);
      wait_ph(0, R + 2);
      check("idle_cleared", int'({LED, opp_led, win, lose, tie, busy}), 0);
      check("p_retained", int'(p_score), 1);
      // early byte in the countdown and a start while busy must both be ignored
      @(negedge sck) start = 1'b1;
      @(negedge sck) start = 1'b0;
      done = 1'b1;
      SIG = 8'h20;
      @(negedge sck) done = 1'b0;
      SIG = 8'h00;
      start = 1'b1;
      @(negedge sck) start = 1'b0;
      wait_ph(2, 3 * B);
      check("early_ignored", int'({LED, win, lose, tie}), 0);
      done = 1'b1;
      SIG = 8'h40;
      @(negedge sck) done = 1'b0;
      SIG = 8'h00;
      check("paper_led", int'(LED), 'b010);
      wait_ph(0, R + 2);
      repeat (3) @(negedge sck);
      check("no_second_round", int'(busy), 0);
      ob = m.o;
      start_round();
      wait_ph(3, T + 2);
      check("timeout_led", int'(LED), 0);
      check("timeout_flags", int'({win, lose, tie}), 'b010);
      @(negedge sck);
      check("timeout_o_score", int'(o_score), ob + 1);
      wait_ph(0, R + 2);
      start_round();
      repeat (T - 1) @(negedge sck);
      done = 1'b1;
      SIG = 8'h80;
      @(negedge sck) done = 1'b0;
      SIG = 8'h00;
      check("timeout_edge_led", int'(LED), 'b100);
      for (int i = 0; i < 4; i++) begin
         wait_ph(0, R + 2);
         start_round();
         send_when(2, 8'h80);
         check("sat_win", int'(win), 1);
      end
      wait_ph(0, R + 2);
      check("p_saturated", int'(p_score), 3);
      ob = m.o;
      start_round();
      send_when(2, 8'h20);
      check("tie_flags", int'({win, lose, tie}), 'b001);
      wait_ph(0, R + 2);
      check("tie_scores", int'({p_score, o_score}), int'({2'd3, 2'(ob)}));
      start_round();
      @(negedge sck);
      #2 reset = 1'b1;
      #1 check("reset_mid_wait", int'(all_out), 0);
      @(negedge sck) reset = 1'b0;
      start_round();
      send_when(2, 8'h80);
      @(negedge sck);
      check("pre_reset_p", int'(p_score), 1);
      #2 reset = 1'b1;
      #1 check("reset_mid_result", int'(all_out), 0);
      @(negedge sck) reset = 1'b0;
      repeat (2) @(negedge sck);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
